// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// grant ids and default tuning parameters.
package dmem_port_arbiter_pkg;

  // 2-bit FSM encoding; IDLE is all-zero so a reset state reads as 0.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Grant ids.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Defaults for the top-level parameters.
  localparam int unsigned DEF_AUX_MAX_WAIT = 8;
  localparam int unsigned DEF_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/dmem_arb_age_counter.sv
// dmem_arb_age_counter
// Saturating 8-bit age counter for the auxiliary port. Clear has priority
// over increment; the count sticks at 255.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   inc_i           count this cycle
//   clr_i           return to zero
//   at_thresh_o     age >= THRESH
module dmem_arb_age_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned THRESH = DEF_AUX_MAX_WAIT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_thresh_o
);

  logic [7:0] r_age;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_age <= 8'd0;
    end else if (clr_i) begin
      r_age <= 8'd0;
    end else if (inc_i && (r_age != 8'hFF)) begin
      r_age <= r_age + 8'd1;
    end
  end

  assign at_thresh_o = (r_age >= 8'(THRESH));

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the CPU load/store path
// (port 0) and an auxiliary bus master (port 1). One request is latched at a
// time, the memory enable is pulsed for one cycle, the memory busy output is
// tracked (with timeout abort) and completion is signalled by a one-cycle ack.
//
// Handshake: a requester raises pN_req_i with its fields and holds req high
// until pN_ack_o pulses. Fields are sampled only at the IDLE grant; pN_r_data_o
// is meaningful only while pN_ack_o is high (0 otherwise). Dropping req after
// the grant does not cancel the transaction. err_o pulses with the ack when
// the memory stayed busy for BUSY_TIMEOUT cycles (read data is then 0).
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   p0_*/p1_* inputs               request, addr, write data, write enable, size/sign
//   p0_ack_o/p1_ack_o, *_r_data_o  completion pulse and read data
//   err_o                          timeout abort flag (with ack)
//   cpu_stall_o                    p0_req_i & ~p0_ack_o
//   mem_*                          data memory interface
//   dbg_state_o                    current FSM state
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AUX_MAX_WAIT = DEF_AUX_MAX_WAIT,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        p0_req_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_w_data_i,
  input  logic        p0_w_ena_i,
  input  logic [3:0]  p0_sign_mask_i,
  input  logic        p1_req_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_w_data_i,
  input  logic        p1_w_ena_i,
  input  logic [3:0]  p1_sign_mask_i,
  output logic        p0_ack_o,
  output logic [31:0] p0_r_data_o,
  output logic        p1_ack_o,
  output logic [31:0] p1_r_data_o,
  output logic        err_o,
  output logic        cpu_stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_w_data_o,
  output logic        mem_w_ena_o,
  output logic        mem_r_ena_o,
  output logic [3:0]  mem_sign_mask_o,
  input  logic [31:0] mem_r_data_i,
  input  logic        mem_busy_i,
  output logic [1:0]  dbg_state_o
);

  localparam logic [9:0] BUSY_LAST = 10'(BUSY_TIMEOUT - 1);

  arb_state_e  r_state;
  arb_state_e  w_next;
  logic        r_grant;
  logic [31:0] r_addr;
  logic [31:0] r_w_data;
  logic        r_w_ena;
  logic [3:0]  r_sign_mask;
  logic [31:0] r_r_data;
  logic        r_err;
  logic [9:0]  r_busy_cnt;

  logic w_req_any;
  logic w_age_hit;
  logic w_pick_aux;
  logic w_age_inc;
  logic w_age_clr;
  logic w_timeout;

  assign w_req_any  = p0_req_i | p1_req_i;
  // Aux wins if it has aged out, or if the CPU is not asking at all.
  assign w_pick_aux = p1_req_i & (w_age_hit | ~p0_req_i);
  assign w_timeout  = mem_busy_i & (r_busy_cnt == BUSY_LAST);

  // Age runs while aux waits without holding the grant (ISSUE..DONE).
  assign w_age_inc = p1_req_i & ~((r_state != ST_IDLE) & (r_grant == PORT_AUX));
  assign w_age_clr = ~p1_req_i | ((r_state == ST_IDLE) & w_pick_aux);

  dmem_arb_age_counter #(
    .THRESH (AUX_MAX_WAIT)
  ) u_age (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .inc_i       (w_age_inc),
    .clr_i       (w_age_clr),
    .at_thresh_o (w_age_hit)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_grant     <= PORT_CPU;
      r_addr      <= 32'd0;
      r_w_data    <= 32'd0;
      r_w_ena     <= 1'b0;
      r_sign_mask <= 4'd0;
      r_r_data    <= 32'd0;
      r_err       <= 1'b0;
      r_busy_cnt  <= 10'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant     <= w_pick_aux ? PORT_AUX : PORT_CPU;
            r_addr      <= w_pick_aux ? p1_addr_i      : p0_addr_i;
            r_w_data    <= w_pick_aux ? p1_w_data_i    : p0_w_data_i;
            r_w_ena     <= w_pick_aux ? p1_w_ena_i     : p0_w_ena_i;
            r_sign_mask <= w_pick_aux ? p1_sign_mask_i : p0_sign_mask_i;
          end
        end
        ST_ISSUE: begin
          r_busy_cnt <= 10'd0;
          r_err      <= 1'b0;
        end
        ST_WAIT: begin
          if (!mem_busy_i) begin
            r_r_data <= mem_r_data_i;
          end else if (w_timeout) begin
            r_r_data <= 32'd0;
            r_err    <= 1'b1;
          end else begin
            r_busy_cnt <= r_busy_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_any) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (!mem_busy_i || w_timeout) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_r_ena_o = 1'b0;
    mem_w_ena_o = 1'b0;
    p0_ack_o    = 1'b0;
    p1_ack_o    = 1'b0;
    err_o       = 1'b0;
    p0_r_data_o = 32'd0;
    p1_r_data_o = 32'd0;
    if (r_state == ST_ISSUE) begin
      mem_w_ena_o = r_w_ena;
      mem_r_ena_o = ~r_w_ena;
    end
    if (r_state == ST_DONE) begin
      err_o = r_err;
      if (r_grant == PORT_AUX) begin
        p1_ack_o    = 1'b1;
        p1_r_data_o = r_r_data;
      end else begin
        p0_ack_o    = 1'b1;
        p0_r_data_o = r_r_data;
      end
    end
  end

  // Latched fields stay on the memory bus from ISSUE through DONE.
  assign mem_addr_o      = r_addr;
  assign mem_w_data_o    = r_w_data;
  assign mem_sign_mask_o = r_sign_mask;
  assign cpu_stall_o     = p0_req_i & ~p0_ack_o;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter with a small memory model and a
// scoreboard of expected {err, port, r_data} completions.
module tb_dmem_port_arbiter;

  localparam int unsigned AUX_MAX_WAIT = 8;
  localparam int unsigned BUSY_TIMEOUT = 64;
  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

  logic        clk;
  logic        reset;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr, p0_w_data, p1_w_data;
  logic        p0_w_ena, p1_w_ena;
  logic [3:0]  p0_mask, p1_mask;
  logic        p0_ack, p1_ack, err, cpu_stall;
  logic [31:0] p0_r_data, p1_r_data;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        mem_w_ena, mem_r_ena, mem_busy;
  logic [3:0]  mem_mask;
  logic [1:0]  dbg_state;

  // memory model controls
  int          busy_len;
  int          busy_cnt;
  logic        busy_stuck;
  logic        rd_ovr_en;
  logic [31:0] rd_ovr;

  // scoreboard
  logic [33:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  int          ack_count;

  dmem_port_arbiter #(
    .AUX_MAX_WAIT (AUX_MAX_WAIT),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .p0_req_i        (p0_req),
    .p0_addr_i       (p0_addr),
    .p0_w_data_i     (p0_w_data),
    .p0_w_ena_i      (p0_w_ena),
    .p0_sign_mask_i  (p0_mask),
    .p1_req_i        (p1_req),
    .p1_addr_i       (p1_addr),
    .p1_w_data_i     (p1_w_data),
    .p1_w_ena_i      (p1_w_ena),
    .p1_sign_mask_i  (p1_mask),
    .p0_ack_o        (p0_ack),
    .p0_r_data_o     (p0_r_data),
    .p1_ack_o        (p1_ack),
    .p1_r_data_o     (p1_r_data),
    .err_o           (err),
    .cpu_stall_o     (cpu_stall),
    .mem_addr_o      (mem_addr),
    .mem_w_data_o    (mem_w_data),
    .mem_w_ena_o     (mem_w_ena),
    .mem_r_ena_o     (mem_r_ena),
    .mem_sign_mask_o (mem_mask),
    .mem_r_data_i    (mem_r_data),
    .mem_busy_i      (mem_busy),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Busy is raised for busy_len cycles starting the cycle after an enable.
  always @(posedge clk) begin
    if (mem_r_ena || mem_w_ena) busy_cnt <= busy_len;
    else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
  end
  assign mem_busy   = busy_stuck || (busy_cnt != 0);
  assign mem_r_data = rd_ovr_en ? rd_ovr : (mem_addr ^ RD_KEY);

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && (p0_ack || p1_ack)) begin
      ack_count++;
      chk("dual_ack", {63'd0, p0_ack & p1_ack}, 64'd0);
      chk("idle_rdata", p1_ack ? {32'd0, p0_r_data} : {32'd0, p1_r_data}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("ack_result", {30'd0, err, p1_ack, p1_ack ? p1_r_data : p0_r_data}, {30'd0, e});
      end
    end else if (!reset) begin
      chk("err_without_ack", {63'd0, err}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_port(input logic port, input logic req, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic wena, input logic [3:0] mask);
    if (port == 1'b0) begin
      p0_req = req; p0_addr = addr; p0_w_data = wdata; p0_w_ena = wena; p0_mask = mask;
    end else begin
      p1_req = req; p1_addr = addr; p1_w_data = wdata; p1_w_ena = wena; p1_mask = mask;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {56'd0, p0_ack, p1_ack, err, cpu_stall, mem_w_ena, mem_r_ena, dbg_state}, 64'd0);
    chk({tag, "_addr_wdata"}, {mem_addr, mem_w_data}, 64'd0);
    chk({tag, "_rdata_mask"}, {p0_r_data, p1_r_data ^ {28'd0, mem_mask}}, 64'd0);
  endtask

  // One transaction on one port, started in IDLE. Checks latency, enable
  // pulses, stall, field pass-through and that the bus address holds.
  task automatic run_txn(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wena, input logic [3:0] mask, input int busy,
                         input logic stuck, input int exp_lat, input logic chg_addr);
    int n_r, n_w, n_stall, bad_addr, other_ack, lat;
    logic got;
    logic [3:0]  seen_mask;
    logic [31:0] seen_wdata;
    n_r = 0; n_w = 0; n_stall = 0; bad_addr = 0; other_ack = 0; lat = -1; got = 1'b0;
    seen_mask = 4'd0; seen_wdata = 32'd0;
    busy_len = busy;
    busy_stuck = stuck;
    if (stuck)          exp_q.push_back({1'b1, port, 32'd0});
    else if (rd_ovr_en) exp_q.push_back({1'b0, port, rd_ovr});
    else                exp_q.push_back({1'b0, port, addr ^ RD_KEY});
    drive_port(port, 1'b1, addr, wdata, wena, mask);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (mem_r_ena) n_r++;
      if (mem_w_ena) n_w++;
      if (mem_r_ena || mem_w_ena) begin
        seen_mask = mem_mask;
        seen_wdata = mem_w_data;
      end
      if (cpu_stall) n_stall++;
      if (cyc >= 1 && mem_addr != addr) bad_addr++;
      if ((port == 1'b0) ? p1_ack : p0_ack) other_ack++;
      if ((port == 1'b0) ? p0_ack : p1_ack) begin
        lat = cyc;
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (chg_addr && cyc == 1) drive_port(port, 1'b1, addr + 32'h10, wdata ^ 32'hFFFF, wena, mask);
    end
    if (!got) chk("ack_timeout", 64'd0, 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("r_ena_pulses", 64'(n_r), 64'(wena ? 0 : 1));
    chk("w_ena_pulses", 64'(n_w), 64'(wena ? 1 : 0));
    chk("stall_cycles", 64'(n_stall), (port == 1'b0) ? 64'(exp_lat) : 64'd0);
    chk("sign_mask", {60'd0, seen_mask}, {60'd0, mask});
    if (wena) chk("w_data", {32'd0, seen_wdata}, {32'd0, wdata});
    chk("addr_hold", 64'(bad_addr), 64'd0);
    chk("other_ack", 64'(other_ack), 64'd0);
    busy_stuck = 1'b0;
    @(posedge clk);
    #1;
    drive_port(port, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; ack_count = 0;
    busy_len = 0; busy_cnt = 0; busy_stuck = 1'b0;
    rd_ovr_en = 1'b0; rd_ovr = 32'd0;
    drive_port(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    drive_port(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // Port 0 read, memory returns 0xDEADBEEF, never busy.
    rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h1000, 32'h0, 1'b0, 4'h2, 0, 1'b0, 3, 1'b0);
    rd_ovr_en = 1'b0;

    // Port 1 write, busy for 4 cycles.
    run_txn(1'b1, 32'h2000, 32'h0000_00A5, 1'b1, 4'h0, 4, 1'b0, 7, 1'b0);

    // Both ports request continuously; aux wins once its age reaches 8.
    begin
      int base;
      busy_len = 0;
      base = ack_count;
      exp_q.push_back({1'b0, 1'b0, 32'h100 ^ RD_KEY});
      exp_q.push_back({1'b0, 1'b0, 32'h100 ^ RD_KEY});
      exp_q.push_back({1'b0, 1'b1, 32'h200 ^ RD_KEY});
      exp_q.push_back({1'b0, 1'b0, 32'h100 ^ RD_KEY});
      exp_q.push_back({1'b0, 1'b0, 32'h100 ^ RD_KEY});
      exp_q.push_back({1'b0, 1'b1, 32'h200 ^ RD_KEY});
      drive_port(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 4'h2);
      drive_port(1'b1, 1'b1, 32'h200, 32'h0, 1'b0, 4'h2);
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #1;
        if (ack_count - base >= 6) break;
      end
      drive_port(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      drive_port(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      chk("arb_ack_count", 64'(ack_count - base), 64'd6);
      chk("arb_queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
    end

    // Busy stuck high: abort after BUSY_TIMEOUT busy cycles in WAIT.
    run_txn(1'b0, 32'h3000, 32'h0, 1'b0, 4'h2, 0, 1'b1, 2 + BUSY_TIMEOUT, 1'b0);
    run_txn(1'b0, 32'h3004, 32'h0, 1'b0, 4'h2, 1, 1'b0, 4, 1'b0);

    // Address change during WAIT is ignored.
    run_txn(1'b0, 32'h10, 32'h1234, 1'b1, 4'h2, 3, 1'b0, 6, 1'b1);

    // Reset during WAIT discards the transaction.
    begin
      int base;
      base = ack_count;
      busy_len = 10;
      drive_port(1'b1, 1'b1, 32'h4000, 32'h0, 1'b0, 4'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_state", {62'd0, dbg_state}, 64'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_port(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      @(negedge clk);
      check_reset_outputs("wait_reset");
      repeat (20) @(posedge clk);
      #1;
      chk("no_ack_after_reset", 64'(ack_count - base), 64'd0);
      busy_len = 0;
    end

    // Randomised single-port transactions.
    for (int i = 0; i < 8; i++) begin
      logic        port, wena;
      logic [31:0] addr, wdata;
      logic [3:0]  mask;
      int          busy;
      port  = 1'($urandom_range(0, 1));
      wena  = 1'($urandom_range(0, 1));
      addr  = {14'd0, 16'($urandom_range(0, 65535)), 2'b00};
      wdata = $urandom;
      mask  = 4'($urandom_range(0, 15));
      busy  = $urandom_range(0, 5);
      run_txn(port, addr, wdata, wena, mask, busy, 1'b0, 3 + busy, 1'b0);
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
